// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle control path: opcodes, ALU ops, mux selects, FSM states.
// Pure declarations; no logic, no timing.
package multicycle_pkg;

    localparam logic [5:0] OP_RTYPE   = 6'b000000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;

    localparam logic [5:0] ALU_ADD = 6'b000000;
    localparam logic [5:0] ALU_SUB = 6'b000100;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [3:0] S_INIT     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_EXEC_R   = 4'd3;
    localparam logic [3:0] S_WB_R     = 4'd4;
    localparam logic [3:0] S_EXEC_I   = 4'd5;
    localparam logic [3:0] S_WB_I     = 4'd6;
    localparam logic [3:0] S_MEM_ADDR = 4'd7;
    localparam logic [3:0] S_MEM_RD   = 4'd8;
    localparam logic [3:0] S_MEM_WR   = 4'd9;
    localparam logic [3:0] S_WB_MEM   = 4'd10;
    localparam logic [3:0] S_BRANCH   = 4'd11;
    localparam logic [3:0] S_FAULT    = 4'd12;

    typedef struct packed {
        logic [5:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       pc_src;
        logic       pc_write;
        logic       ir_write;
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       instr_done;
        logic       fault;
    } ctrl_t;

    // States that sit on the memory handshake and are therefore watched by the timer.
    function automatic logic is_wait_state(input logic [3:0] s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_wait_timer.sv
// Saturating wait counter; expired_o is combinational on the cycle the count would reach TIMEOUT_CYCLES.
// No handshake: clr_i has priority over inc_i; TIMEOUT_CYCLES=0 never expires.
module multicycle_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int WAIT_W         = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int              LIMIT_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(LIMIT_I);
    localparam logic [WAIT_W-1:0] CNT_MAX = '1;

    logic [WAIT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            assign expired_o = inc_i && (cnt_q >= LIMIT);
        end else begin : g_no_timeout
            assign expired_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM (ADDU/ADDIU/LW/SW/BEQ); Moore outputs plus mem_ready/zero-gated strobes.
// Latency at zero-wait memory: BEQ 3, ADDU/ADDIU/SW 4, LW 5; stalls on mem_ready, faults on timeout.
// MULTICYCLE_CTRL_PERF_EN adds cycle_cnt/retired_cnt performance counters.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int WAIT_W         = 5
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    parameter int CNT_W          = 32
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [5:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       pc_src,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_req,
    output logic       mem_we,
    output logic       i_or_d,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       instr_done,
    output logic       fault
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retired_cnt
`endif
);

    logic [3:0] state_q, state_d;
    logic       wait_st;
    logic       tmr_exp;
    ctrl_t      ctrl;

    assign wait_st = is_wait_state(state_q);

    // Clearing on every state change gives each wait state a fresh budget, even FETCH entered straight from MEM_WR.
    multicycle_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .WAIT_W        (WAIT_W)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (state_d != state_q),
        .inc_i    (wait_st && !mem_ready),
        .expired_o(tmr_exp)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:     state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready)    state_d = S_DECODE;
                else if (tmr_exp) state_d = S_FAULT;
            end
            S_DECODE: begin
                if ((opcode == OP_RTYPE) && (funct == FUNCT_ADDU)) state_d = S_EXEC_R;
                else if (opcode == OP_ADDIU)                       state_d = S_EXEC_I;
                else if ((opcode == OP_LW) || (opcode == OP_SW))   state_d = S_MEM_ADDR;
                else if (opcode == OP_BEQ)                         state_d = S_BRANCH;
                else                                               state_d = S_FAULT;
            end
            S_EXEC_R:   state_d = S_WB_R;
            S_WB_R:     state_d = S_FETCH;
            S_EXEC_I:   state_d = S_WB_I;
            S_WB_I:     state_d = S_FETCH;
            S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ready)    state_d = S_WB_MEM;
                else if (tmr_exp) state_d = S_FAULT;
            end
            S_MEM_WR: begin
                if (mem_ready)    state_d = S_FETCH;
                else if (tmr_exp) state_d = S_FAULT;
            end
            S_WB_MEM:   state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_FAULT:    state_d = S_FAULT;
            default:    state_d = S_FAULT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALU_ADD;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_ADD;
            end
            S_WB_R: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = OP_ADDIU;
            end
            S_WB_I: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = opcode;
            end
            S_MEM_RD: begin
                ctrl.mem_req = 1'b1;
                ctrl.i_or_d  = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_req    = 1'b1;
                ctrl.mem_we     = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_WB_MEM: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_REG;
                ctrl.alu_op     = ALU_SUB;
                ctrl.pc_src     = 1'b1;
                ctrl.pc_write   = zero;
                ctrl.instr_done = 1'b1;
            end
            S_FAULT: begin
                ctrl.fault = 1'b1;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

    assign alu_op     = ctrl.alu_op;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign pc_src     = ctrl.pc_src;
    assign pc_write   = ctrl.pc_write;
    assign ir_write   = ctrl.ir_write;
    assign mem_req    = ctrl.mem_req;
    assign mem_we     = ctrl.mem_we;
    assign i_or_d     = ctrl.i_or_d;
    assign reg_write  = ctrl.reg_write;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign instr_done = ctrl.instr_done;
    assign fault      = ctrl.fault;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q;
        retired_cnt_d = retired_cnt_q;
        if (state_q != S_FAULT) begin
            cycle_cnt_d = cycle_cnt_q + 1'b1;
            if (ctrl.instr_done) begin
                retired_cnt_d = retired_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q   <= '0;
            retired_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign retired_cnt = retired_cnt_q;
`endif

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle version of the processor datapath.
- Sequences the shared 32-bit ALU, instruction/data memory port, PC and register file across FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK cycles.
- Drives the ALU op_code (6-bit, same encoding as the ALU: opcode values) and operand muxes; consumes ALU zero flag and memory ready handshake.
- Supports ADDU, ADDIU, LW, SW, BEQ; anything else traps to a sticky fault state.

Parameters:
TIMEOUT_CYCLES, 16, max cycles waiting for mem_ready before fault; 0 disables timeout
WAIT_W, 5, width of wait counter; must hold TIMEOUT_CYCLES
CNT_W, 32, width of perf counters (optional feature only)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current request this cycle
alu_op  out  6  ALU op_code
alu_src_a  out  1  0=PC, 1=reg A
alu_src_b  out  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
pc_src  out  1  0=ALU result, 1=ALUOut register
pc_write  out  1  PC load strobe
ir_write  out  1  IR load strobe
mem_req  out  1  memory request
mem_we  out  1  memory write (valid with mem_req)
i_or_d  out  1  memory address 0=PC, 1=ALUOut
reg_write  out  1  register file write
reg_dst  out  1  0=rt, 1=rd
mem_to_reg  out  1  0=ALUOut, 1=MDR
instr_done  out  1  one-cycle pulse at instruction retire
fault  out  1  sticky; illegal instr or memory timeout

Behaviour:
- Reset (rst_n low, async): state=INIT; all outputs 0, alu_op=000000. INIT lasts 1 cycle, outputs all 0, -> FETCH. Reset mid-instruction aborts it; no strobe during/after reset until FETCH.
- Outputs are combinational from state (Moore), except pc_write/ir_write in FETCH (gated by mem_ready) and pc_write in BRANCH (=zero). Unlisted outputs 0; alu_op default 000000.
- FETCH: mem_req=1, i_or_d=0, src_a=0, src_b=01, alu_op=000000. mem_ready=1: ir_write=1, pc_write=1, pc_src=0, -> DECODE; else stay.
- DECODE: src_a=0, src_b=11, alu_op=000000 (branch target into ALUOut). Next: opcode 000000 & funct 100001 -> EXEC_R; 001001 -> EXEC_I; 100011/101011 -> MEM_ADDR; 000100 -> BRANCH; else -> FAULT.
- EXEC_R: src_a=1, src_b=00, alu_op=000000 -> WB_R. WB_R: reg_write=1, reg_dst=1, instr_done=1 -> FETCH.
- EXEC_I: src_a=1, src_b=10, alu_op=001001 -> WB_I. WB_I: reg_write=1, reg_dst=0, instr_done=1 -> FETCH.
- MEM_ADDR: src_a=1, src_b=10, alu_op=opcode -> MEM_RD (LW) or MEM_WR (SW); opcode latched in DECODE, held stable by IR.
- MEM_RD: mem_req=1, i_or_d=1; on mem_ready -> WB_MEM (reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1) -> FETCH.
- MEM_WR: mem_req=1, mem_we=1, i_or_d=1; on mem_ready: instr_done=1 -> FETCH.
- BRANCH: src_a=1, src_b=00, alu_op=000100, pc_src=1, pc_write=zero, instr_done=1 -> FETCH.
- Latency with zero-wait memory: BEQ 3, ADDU/ADDIU/SW 4, LW 5 cycles.
- Wait counter: cleared on entry to FETCH/MEM_RD/MEM_WR, increments each cycle without mem_ready; if TIMEOUT_CYCLES>0 and count reaches TIMEOUT_CYCLES -> FAULT. mem_ready in the same cycle as expiry wins (normal advance). Counter saturates; no wrap.
- FAULT: all strobes 0, fault=1; exits only via reset.

Optional Feature:
- MULTICYCLE_CTRL_PERF_EN defined: adds outputs cycle_cnt[CNT_W] (increments every cycle out of reset, wraps) and retired_cnt[CNT_W] (increments on instr_done, wraps); both reset to 0, frozen in FAULT.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package multicycle_pkg: opcode constants (OP_RTYPE, OP_ADDIU, OP_LW, OP_SW, OP_BEQ), FUNCT_ADDU, ALU op constants (ALU_ADD=000000, ALU_SUB=000100), alu_src_b encodings, state enum.
- Sub-module multicycle_wait_timer: clear/inc/expired counter parameterised by TIMEOUT_CYCLES, WAIT_W.

Test Plan:
- Reset then ADDU (op 000000, funct 100001), mem_ready tied 1 -> INIT, FETCH, DECODE, EXEC_R, WB_R; reg_write=1 & reg_dst=1 on cycle 4 after INIT; instr_done 1 cycle.
- LW (100011) with mem_ready delayed 3 cycles in MEM_RD -> mem_req/i_or_d held 3 cycles, WB_MEM mem_to_reg=1, total 8 cycles.
- BEQ (000100), zero=1 then zero=0 -> pc_write=1/pc_src=1 in BRANCH vs pc_write=0; alu_op=000100.
- Illegal opcode 000010 and opcode 0 funct 100000 -> FAULT after DECODE, fault=1 until rst_n low; no further mem_req.
- mem_ready held 0 in FETCH, TIMEOUT_CYCLES=16 -> FAULT after 16 cycles; ready on cycle 16 -> DECODE instead.
- rst_n asserted mid MEM_WR -> outputs 0 immediately (async), INIT then FETCH; with PERF_EN counters back to 0.
